gigatron_core: RTL and testbench
================================

# gigatron_core

Parametrised second-generation Gigatron-ISA execution core for the board top, between the instruction ROM, the RAM and the VGA/IO pins. It runs the 8-bit Gigatron instruction set with its one-slot branch delay and adds a configurable RAM width with bank switching. It also adds fetch/memory wait handshakes, a debug halt with single-step, and a retired-instruction counter.

## Interface
- `ADDR_W`, 15, RAM address width; legal values are 15, 16 and 17.
- `RESET_PC`, 16'h0000, fetch address after reset.
- `CNT_W`, 32, width of the retired-instruction counter.
- `clock`  in  1  core clock. Single clock domain; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  out  16  instruction fetch address.
- `ir`  in  16  instruction word for `pc`.
- `ir_valid`  in  1  `ir` is valid this cycle.
- `r_addr`  out  ADDR_W  RAM read address (combinational).
- `i_data`  in  8  RAM read data.
- `mem_ready`  in  1  `i_data` is valid.
- `w_addr`  out  ADDR_W  RAM write address.
- `o_data`  out  8  RAM write data.
- `o_we`  out  1  RAM write strobe, one cycle.
- `inreg`  in  8  input port.
- `vga`  out  8  output port.
- `outx`  out  8  extended output latch.
- `ctrl`  out  8  control register; bits 7:6 select the RAM bank.
- `halt_req`  in  1  level; stop at the next instruction boundary.
- `step`  in  1  single-cycle pulse; while halted, execute exactly one instruction.
- `halted`  out  1  core is halted.
- `retired`  out  CNT_W  count of executed instructions, wrapping.

## Operation
- Instruction fields: op=ir[15:13], mode=ir[12:10], bus=ir[9:8], d=ir[7:0].
- Operand B by bus: 0 = d, 1 = RAM, 2 = ac, 3 = inreg.
- ALU by op: 0 LD (B), 1 AND, 2 OR, 3 XOR, 4 ADD, 5 SUB. All results are mod 256 with no flags.
- Effective address E (16 bit):
  - Branch ops (op=7): {8'h00,d}.
  - Modes 0, 4, 5, 6: {8'h00,d}. Mode 1: {8'h00,x}. Mode 2: {y,d}. Modes 3 and 7: {y,x}.
- Mapping of E to `r_addr`:
  - ADDR_W=15: E[14:0].
  - ADDR_W=16: E.
  - ADDR_W=17: E[15] ? {ctrl[7:6],E[14:0]} : {2'b00,E[14:0]}.
- ALU destinations by mode: 0–3 write ac; 4 writes x; 5 writes y; 6 and 7 write `vga`.
  - Mode 7 with bus=1 also post-increments x.
  - When a write to `vga` has vga[6]=0 and the new value bit 6=1, `outx` takes the pre-instruction ac.
- Store (op=6): `w_addr`=mapped E, `o_data`=B, `o_we`=1.
  - Mode 4 also writes x←B; mode 5 also writes y←B; mode 7 increments x.
  - With bus=1, the store is a control write instead: ctrl←d, no RAM write, no memory stall.
- Branch (op=7): ac is compared as signed against 0.
  - Mode 0 JMP: target {y,B}.
  - Modes 1–6 (GT, LT, NE, EQ, GE, LE): target {pc[15:8]+carry of the delay-slot pc, B}.
  - Mode 7 BRA: unconditional.
- Advance = ir_valid && !(needs_mem && !mem_ready) && (!halted || step). needs_mem = bus==1 and not a control write.
  - On a non-advance cycle, no architectural state changes and `o_we`=0.
- Halt:
  - `halt_req` seen on an advancing edge → `halted`=1 after that instruction retires.
  - While halted, each `step` pulse allows one advance. A step that coincides with a stall is held pending until the advance happens.
  - Deasserting `halt_req` while halted → `halted`=0 on the next edge.
- `retired` increments on each advance and wraps.

## Timing
- Reset values: pc=RESET_PC, internal nextpc=RESET_PC+1, ac=x=y=0, vga=outx=ctrl=0, o_we=0, w_addr=o_data=0, halted=0, retired=0. Reset is honoured mid-stall and mid-step.
- One instruction per advancing cycle. `pc` is registered and updates on every advance.
- Branch delay: a taken branch at P gives the pc sequence P, P+1, T, T+1. The delay slot always executes.
- `o_we`, `w_addr` and `o_data` are registered: they appear in the cycle after the store's advance and last exactly one cycle.
- `r_addr` is combinational from ir, x, y and ctrl. `mem_ready` is sampled in the same cycle.
- A bank change via `ctrl` affects the next instruction's address.

## Structure
- Shared package `gigatron_pkg`: op, mode and bus localparams, and the ADDR_W legal-range check.
- Sub-module `gigatron_alu`: a combinational B mux, ALU and branch-condition unit. Everything else stays in `gigatron_core`.

## Test plan
- Reset with RESET_PC=16'h0100 → pc=0100, 0101, 0102, … and all other outputs 0.
- Sequence LD #$05; ADD #$FC; BNE → ac=01 and branch taken. The delay-slot instruction executes; pc goes P, P+1, T.
- ADDR_W=17, ST ctrl←$C0, then ST [y,x] with y=$80, x=$10 → w_addr=17'h18010 and o_we for exactly one cycle.
- LD [$20] with mem_ready low for 3 cycles → pc and ac hold, retired frozen; the load completes on the 4th cycle.
- Write vga=$00, then write vga=$40 with ac=$5A → outx=$5A.
- Assert halt_req → halted=1 with pc frozen; 2 step pulses → retired +2 and pc +2.

Source files
------------

// File: rtl/gigatron_pkg.sv
// Shared encodings for the Gigatron-ISA core: instruction fields, opcodes, modes and buses.
package gigatron_pkg;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] mode;
        logic [1:0] bus;
        logic [7:0] d;
    } instr_t;

    localparam logic [2:0] OP_LD  = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_ST  = 3'd6;
    localparam logic [2:0] OP_BR  = 3'd7;

    localparam logic [2:0] MODE_D_AC    = 3'd0;
    localparam logic [2:0] MODE_X_AC    = 3'd1;
    localparam logic [2:0] MODE_YD_AC   = 3'd2;
    localparam logic [2:0] MODE_YX_AC   = 3'd3;
    localparam logic [2:0] MODE_D_X     = 3'd4;
    localparam logic [2:0] MODE_D_Y     = 3'd5;
    localparam logic [2:0] MODE_D_OUT   = 3'd6;
    localparam logic [2:0] MODE_YXI_OUT = 3'd7;

    localparam logic [2:0] BR_JMP = 3'd0;
    localparam logic [2:0] BR_GT  = 3'd1;
    localparam logic [2:0] BR_LT  = 3'd2;
    localparam logic [2:0] BR_NE  = 3'd3;
    localparam logic [2:0] BR_EQ  = 3'd4;
    localparam logic [2:0] BR_GE  = 3'd5;
    localparam logic [2:0] BR_LE  = 3'd6;
    localparam logic [2:0] BR_BRA = 3'd7;

    localparam logic [1:0] BUS_D   = 2'd0;
    localparam logic [1:0] BUS_RAM = 2'd1;
    localparam logic [1:0] BUS_AC  = 2'd2;
    localparam logic [1:0] BUS_IN  = 2'd3;

    function automatic bit addr_w_legal(input int unsigned w);
        return (w >= 15) && (w <= 17);
    endfunction

endpackage

// File: rtl/gigatron_alu.sv
// Combinational operand-B mux, 8-bit ALU and branch-condition evaluation.
module gigatron_alu
    import gigatron_pkg::*;
(
    input  logic [2:0] op,
    input  logic [2:0] mode,
    input  logic [1:0] bus,
    input  logic [7:0] d,
    input  logic [7:0] ram,
    input  logic [7:0] ac,
    input  logic [7:0] inreg,
    output logic [7:0] b,
    output logic [7:0] result,
    output logic       taken
);

    always_comb begin
        unique case (bus)
            BUS_D:   b = d;
            BUS_RAM: b = ram;
            BUS_AC:  b = ac;
            default: b = inreg;
        endcase
    end

    always_comb begin
        case (op)
            OP_AND:  result = ac & b;
            OP_OR:   result = ac | b;
            OP_XOR:  result = ac ^ b;
            OP_ADD:  result = ac + b;
            OP_SUB:  result = ac - b;
            default: result = b;
        endcase
    end

    // ac is treated as signed: bit 7 is the sign, zero is tested separately.
    always_comb begin
        unique case (mode)
            BR_JMP:  taken = 1'b1;
            BR_GT:   taken = !ac[7] && (ac != 8'h00);
            BR_LT:   taken = ac[7];
            BR_NE:   taken = (ac != 8'h00);
            BR_EQ:   taken = (ac == 8'h00);
            BR_GE:   taken = !ac[7];
            BR_LE:   taken = ac[7] || (ac == 8'h00);
            default: taken = 1'b1;
        endcase
    end

endmodule

// File: rtl/gigatron_core.sv
// Gigatron-ISA execution core with banked RAM addressing, fetch/memory stalls,
// debug halt/single-step and a retired-instruction counter.
module gigatron_core
    import gigatron_pkg::*;
#(
    parameter int unsigned ADDR_W   = 15,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clock,
    input  logic              rst,
    output logic [15:0]       pc,
    input  logic [15:0]       ir,
    input  logic              ir_valid,
    output logic [ADDR_W-1:0] r_addr,
    input  logic [7:0]        i_data,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        o_data,
    output logic              o_we,
    input  logic [7:0]        inreg,
    output logic [7:0]        vga,
    output logic [7:0]        outx,
    output logic [7:0]        ctrl,
    input  logic              halt_req,
    input  logic              step,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    if (!addr_w_legal(ADDR_W)) begin : g_bad_addr_w
        $error("gigatron_core: ADDR_W must be 15, 16 or 17");
    end

    instr_t ins;
    assign ins = ir;

    logic [15:0]       pc_q, pc_d, nextpc_q, nextpc_d;
    logic [7:0]        ac_q, ac_d, x_q, x_d, y_q, y_d;
    logic [7:0]        vga_q, vga_d, outx_q, outx_d, ctrl_q, ctrl_d;
    logic [7:0]        o_data_q, o_data_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic              o_we_q, o_we_d, halted_q, halted_d, step_pend_q, step_pend_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [15:0]       ea;
    logic [ADDR_W-1:0] maddr;
    logic [7:0]        b, result;
    logic              taken, ctrl_wr, needs_mem, advance;

    gigatron_alu u_alu (
        .op     (ins.op),
        .mode   (ins.mode),
        .bus    (ins.bus),
        .d      (ins.d),
        .ram    (i_data),
        .ac     (ac_q),
        .inreg  (inreg),
        .b      (b),
        .result (result),
        .taken  (taken)
    );

    always_comb begin
        ea = {8'h00, ins.d};
        if (ins.op != OP_BR) begin
            case (ins.mode)
                MODE_X_AC:                ea = {8'h00, x_q};
                MODE_YD_AC:               ea = {y_q, ins.d};
                MODE_YX_AC, MODE_YXI_OUT: ea = {y_q, x_q};
                default:                  ea = {8'h00, ins.d};
            endcase
        end
    end

    if (ADDR_W == 15) begin : g_aw15
        logic unused_ea_msb;
        assign unused_ea_msb = ea[15];
        assign maddr = ea[14:0];
    end else if (ADDR_W == 16) begin : g_aw16
        assign maddr = ea;
    end else begin : g_aw17
        // Upper half of the 16-bit space is banked by ctrl[7:6].
        assign maddr = {(ea[15] ? ctrl_q[7:6] : 2'b00), ea[14:0]};
    end

    assign ctrl_wr   = (ins.op == OP_ST) && (ins.bus == BUS_RAM);
    assign needs_mem = (ins.bus == BUS_RAM) && !ctrl_wr;
    assign advance   = ir_valid && !(needs_mem && !mem_ready)
                       && (!halted_q || step || step_pend_q);

    always_comb begin
        pc_d      = pc_q;
        nextpc_d  = nextpc_q;
        ac_d      = ac_q;
        x_d       = x_q;
        y_d       = y_q;
        vga_d     = vga_q;
        outx_d    = outx_q;
        ctrl_d    = ctrl_q;
        o_we_d    = 1'b0;
        w_addr_d  = w_addr_q;
        o_data_d  = o_data_q;
        retired_d = retired_q;
        if (advance) begin
            pc_d      = nextpc_q;
            nextpc_d  = nextpc_q + 16'd1;
            retired_d = retired_q + CNT_W'(1);
            case (ins.op)
                OP_BR: begin
                    // Conditional targets stay in the delay slot's page.
                    if (taken) begin
                        nextpc_d = (ins.mode == BR_JMP) ? {y_q, b} : {nextpc_q[15:8], b};
                    end
                end
                OP_ST: begin
                    if (ctrl_wr) begin
                        ctrl_d = ins.d;
                    end else begin
                        o_we_d   = 1'b1;
                        w_addr_d = maddr;
                        o_data_d = b;
                        case (ins.mode)
                            MODE_D_X:     x_d = b;
                            MODE_D_Y:     y_d = b;
                            MODE_YXI_OUT: x_d = x_q + 8'd1;
                            default:      ;
                        endcase
                    end
                end
                default: begin
                    case (ins.mode)
                        MODE_D_X: x_d = result;
                        MODE_D_Y: y_d = result;
                        MODE_D_OUT, MODE_YXI_OUT: begin
                            vga_d = result;
                            if (!vga_q[6] && result[6]) outx_d = ac_q;
                            if (ins.mode == MODE_YXI_OUT && ins.bus == BUS_RAM) x_d = x_q + 8'd1;
                        end
                        default: ac_d = result;
                    endcase
                end
            endcase
        end
    end

    always_comb begin
        halted_d = halted_q;
        if (halted_q && !halt_req) begin
            halted_d = 1'b0;
        end else if (advance && halt_req) begin
            halted_d = 1'b1;
        end
    end

    // A step that lands on a stall waits here until the instruction can advance.
    assign step_pend_d = halted_q && halt_req && (step || step_pend_q) && !advance;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            nextpc_q    <= RESET_PC + 16'd1;
            ac_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            vga_q       <= '0;
            outx_q      <= '0;
            ctrl_q      <= '0;
            o_we_q      <= 1'b0;
            w_addr_q    <= '0;
            o_data_q    <= '0;
            halted_q    <= 1'b0;
            step_pend_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            pc_q        <= pc_d;
            nextpc_q    <= nextpc_d;
            ac_q        <= ac_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vga_q       <= vga_d;
            outx_q      <= outx_d;
            ctrl_q      <= ctrl_d;
            o_we_q      <= o_we_d;
            w_addr_q    <= w_addr_d;
            o_data_q    <= o_data_d;
            halted_q    <= halted_d;
            step_pend_q <= step_pend_d;
            retired_q   <= retired_d;
        end
    end

    assign pc      = pc_q;
    assign r_addr  = maddr;
    assign w_addr  = w_addr_q;
    assign o_data  = o_data_q;
    assign o_we    = o_we_q;
    assign vga     = vga_q;
    assign outx    = outx_q;
    assign ctrl    = ctrl_q;
    assign halted  = halted_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_gigatron_core.sv
// Directed and randomized bench for gigatron_core against an instruction-level reference model.
module tb_gigatron_core;

    localparam int AW = 17;

    logic          clock, rst;
    logic [15:0]   pc, ir;
    logic          ir_valid, mem_ready, o_we, halt_req, step, halted;
    logic [AW-1:0] r_addr, w_addr;
    logic [7:0]    i_data, o_data, inreg, vga, outx, ctrl;
    logic [31:0]   retired;

    gigatron_core #(
        .ADDR_W   (AW),
        .RESET_PC (16'h0100),
        .CNT_W    (32)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .pc        (pc),
        .ir        (ir),
        .ir_valid  (ir_valid),
        .r_addr    (r_addr),
        .i_data    (i_data),
        .mem_ready (mem_ready),
        .w_addr    (w_addr),
        .o_data    (o_data),
        .o_we      (o_we),
        .inreg     (inreg),
        .vga       (vga),
        .outx      (outx),
        .ctrl      (ctrl),
        .halt_req  (halt_req),
        .step      (step),
        .halted    (halted),
        .retired   (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one instruction retired per accepted cycle.
    int          m_pc, m_next, m_ac, m_x, m_y, m_vga, m_outx, m_ctrl;
    int          m_we, m_waddr, m_odata, m_raddr;
    bit          m_halted, m_pend;
    int unsigned m_ret;

    task automatic model_reset();
        m_pc = 'h0100; m_next = 'h0101;
        m_ac = 0; m_x = 0; m_y = 0; m_vga = 0; m_outx = 0; m_ctrl = 0;
        m_we = 0; m_waddr = 0; m_odata = 0; m_halted = 0; m_pend = 0; m_ret = 0;
    endtask

    function automatic int map_addr(input int ea);
        if (AW == 15) return ea % 32768;
        if (AW == 16) return ea;
        if (ea >= 32768) return (m_ctrl / 64) * 32768 + (ea % 32768);
        return ea;
    endfunction

    function automatic logic [15:0] enc(input int op, input int mode, input int bus, input int d);
        return 16'((op << 13) | (mode << 10) | (bus << 8) | (d & 255));
    endfunction

    task automatic model_step(input int ins, input int v, input int ram, input int rdy,
                              input int inp, input int hr, input int st);
        int op, mode, bus, d, ea, b, res, sac, tgt;
        bit ctrlw, go, taken, nh;
        op = (ins >> 13) & 7; mode = (ins >> 10) & 7; bus = (ins >> 8) & 3; d = ins & 255;
        if (op == 7 || mode == 0 || (mode >= 4 && mode <= 6)) ea = d;
        else if (mode == 1) ea = m_x;
        else if (mode == 2) ea = m_y * 256 + d;
        else ea = m_y * 256 + m_x;
        m_raddr = map_addr(ea);
        ctrlw = (op == 6) && (bus == 1);
        go = (v != 0) && !(bus == 1 && !ctrlw && rdy == 0) && (!m_halted || st != 0 || m_pend);
        case (bus)
            0: b = d;
            1: b = ram;
            2: b = m_ac;
            default: b = inp;
        endcase
        nh = m_halted;
        if (m_halted && hr == 0) nh = 0;
        else if (go && hr != 0) nh = 1;
        m_pend = m_halted && hr != 0 && (st != 0 || m_pend) && !go;
        m_halted = nh;
        m_we = 0;
        if (!go) return;
        m_ret++;
        tgt = (m_next + 1) % 65536;
        if (op == 7) begin
            sac = (m_ac >= 128) ? m_ac - 256 : m_ac;
            case (mode)
                1: taken = sac > 0;
                2: taken = sac < 0;
                3: taken = sac != 0;
                4: taken = sac == 0;
                5: taken = sac >= 0;
                6: taken = sac <= 0;
                default: taken = 1;
            endcase
            if (taken) tgt = (mode == 0) ? m_y * 256 + b : (m_next & 'hFF00) + b;
        end else if (op == 6) begin
            if (ctrlw) m_ctrl = d;
            else begin
                m_we = 1; m_waddr = m_raddr; m_odata = b;
                if (mode == 4) m_x = b;
                else if (mode == 5) m_y = b;
                else if (mode == 7) m_x = (m_x + 1) % 256;
            end
        end else begin
            case (op)
                0: res = b;
                1: res = m_ac & b;
                2: res = m_ac | b;
                3: res = m_ac ^ b;
                4: res = (m_ac + b) % 256;
                default: res = (m_ac - b + 256) % 256;
            endcase
            if (mode <= 3) m_ac = res;
            else if (mode == 4) m_x = res;
            else if (mode == 5) m_y = res;
            else begin
                if (((m_vga / 64) % 2) == 0 && ((res / 64) % 2) == 1) m_outx = m_ac;
                m_vga = res;
                if (mode == 7 && bus == 1) m_x = (m_x + 1) % 256;
            end
        end
        m_pc = m_next;
        m_next = tgt;
    endtask

    task automatic check_outputs();
        check_eq("pc", 32'(pc), m_pc);
        check_eq("vga", 32'(vga), m_vga);
        check_eq("outx", 32'(outx), m_outx);
        check_eq("ctrl", 32'(ctrl), m_ctrl);
        check_eq("halted", 32'(halted), 32'(m_halted));
        check_eq("retired", retired, m_ret);
        check_eq("o_we", 32'(o_we), m_we);
        if (m_we != 0) begin
            check_eq("w_addr", 32'(w_addr), m_waddr);
            check_eq("o_data", 32'(o_data), m_odata);
        end
    endtask

    task automatic run_cycle(input logic [15:0] t_ir, input logic t_v, input logic [7:0] t_ram,
                             input logic t_rdy, input logic [7:0] t_in, input logic t_hr,
                             input logic t_st);
        @(negedge clock);
        ir = t_ir; ir_valid = t_v; i_data = t_ram; mem_ready = t_rdy;
        inreg = t_in; halt_req = t_hr; step = t_st;
        #1;
        model_step(t_ir, t_v, t_ram, t_rdy, t_in, t_hr, t_st);
        check_eq("r_addr", 32'(r_addr), m_raddr);
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic exec(input logic [15:0] t_ir);
        run_cycle(t_ir, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
    endtask

    logic [15:0] r_ins;
    logic        r_hr, r_st, r_prev;
    int          snap_pc;
    int unsigned snap_ret;

    initial begin
        rst = 1'b1; ir = '0; ir_valid = 1'b0; i_data = '0; mem_ready = 1'b0;
        inreg = '0; halt_req = 1'b0; step = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        check_eq("reset pc", 32'(pc), 32'h0100);
        check_eq("reset o_we", 32'(o_we), 0);
        check_eq("reset w_addr", 32'(w_addr), 0);
        check_eq("reset o_data", 32'(o_data), 0);
        check_outputs();
        rst = 1'b0;

        // Sequential fetch from RESET_PC.
        exec(enc(0, 0, 2, 0));
        check_eq("seq pc1", 32'(pc), 32'h0101);
        exec(enc(0, 0, 2, 0));
        check_eq("seq pc2", 32'(pc), 32'h0102);

        // LD #05; ADD #FC; BNE with delay slot copying ac to vga.
        exec(enc(0, 0, 0, 8'h05));
        exec(enc(4, 0, 0, 8'hFC));
        exec(enc(7, 3, 0, 8'h40));
        check_eq("bne slot pc", 32'(pc), 32'h0105);
        exec(enc(0, 6, 2, 0));
        check_eq("bne target", 32'(pc), 32'h0140);
        check_eq("ac after add", 32'(vga), 32'h01);

        // vga bit 6 rising edge latches pre-instruction ac into outx.
        exec(enc(0, 0, 0, 8'h5A));
        exec(enc(0, 6, 0, 8'h00));
        exec(enc(0, 6, 0, 8'h40));
        check_eq("outx latch", 32'(outx), 32'h5A);

        // Bank select then banked store through [y,x].
        exec(enc(6, 0, 1, 8'hC0));
        check_eq("ctrl bank", 32'(ctrl), 32'hC0);
        exec(enc(0, 5, 0, 8'h80));
        exec(enc(0, 4, 0, 8'h10));
        exec(enc(6, 3, 2, 0));
        check_eq("bank o_we", 32'(o_we), 1);
        check_eq("bank w_addr", 32'(w_addr), 32'h18010);
        check_eq("bank o_data", 32'(o_data), 32'h5A);
        exec(enc(0, 0, 2, 0));
        check_eq("o_we one cycle", 32'(o_we), 0);

        // Memory stall for three cycles, completing on the fourth.
        snap_pc = m_pc; snap_ret = m_ret;
        repeat (3) begin
            run_cycle(enc(0, 0, 1, 8'h20), 1'b1, 8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
            check_eq("stall pc", 32'(pc), snap_pc);
            check_eq("stall retired", retired, snap_ret);
        end
        run_cycle(enc(0, 0, 1, 8'h20), 1'b1, 8'h33, 1'b1, 8'h00, 1'b0, 1'b0);
        check_eq("stall done", 32'(pc), snap_pc + 1);
        exec(enc(0, 6, 2, 0));
        check_eq("stall load", 32'(vga), 32'h33);

        // Halt, then single-step twice, then a step that lands on a stall.
        run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("halt set", 32'(halted), 1);
        snap_pc = m_pc; snap_ret = m_ret;
        repeat (3) run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("halt pc frozen", 32'(pc), snap_pc);
        run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
        run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1);
        check_eq("step pc", 32'(pc), snap_pc + 2);
        check_eq("step retired", retired, snap_ret + 2);
        run_cycle(enc(0, 0, 1, 8'h21), 1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1);
        run_cycle(enc(0, 0, 1, 8'h21), 1'b1, 8'h44, 1'b1, 8'h00, 1'b1, 1'b0);
        check_eq("pending step", 32'(pc), snap_pc + 3);
        run_cycle(enc(0, 0, 2, 0), 1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
        check_eq("unhalt", 32'(halted), 0);

        // Randomized instruction stream with stalls, halts and steps.
        r_hr = 1'b0; r_prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r_ins = 16'($urandom);
            if (r_ins[15:13] == 3'd6 && r_ins[9:8] == 2'd1
                && (r_ins[12:10] == 3'd4 || r_ins[12:10] == 3'd5 || r_ins[12:10] == 3'd7))
                r_ins[12:10] = 3'd0;
            if ($urandom_range(0, 39) == 0) r_hr = !r_hr;
            r_st = 1'b0;
            if (!r_prev && !m_pend && $urandom_range(0, 7) == 0) r_st = 1'b1;
            run_cycle(r_ins, $urandom_range(0, 9) != 0, 8'($urandom),
                      $urandom_range(0, 3) != 0, 8'($urandom), r_hr, r_st);
            r_prev = r_st;
        end

        // Asynchronous reset in the middle of a stall.
        @(negedge clock);
        ir = enc(0, 0, 1, 8'h22); ir_valid = 1'b1; mem_ready = 1'b0;
        halt_req = 1'b0; step = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_eq("async rst pc", 32'(pc), 32'h0100);
        check_eq("async rst retired", retired, 0);
        check_outputs();
        @(negedge clock);
        rst = 1'b0;
        exec(enc(0, 0, 0, 8'h7F));
        exec(enc(0, 6, 2, 0));
        check_eq("post rst vga", 32'(vga), 32'h7F);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
